sync_fifo_buf: RTL and testbench
================================

# sync_fifo_buf

Single-clock FIFO built around a parametrised dual-port word memory, adding write/read pointers, occupancy count, status flags, sticky error flags and a selectable first-word-fall-through (FWFT) read mode. It is the generalised successor to the bare FIFO memory: the caller issues push/pop strobes only and no longer drives addresses or a full qualifier. It sits between a producer and consumer sharing `clk`, and serves as the reference model for the same-clock case of the async FIFO.

## Interface
- `WORDSIZE`, 8, data width in bits
- `ADDRSIZE`, 3, address width; DEPTH = 2^ADDRSIZE words
- `AFULL_LVL`, DEPTH-2, `afull` asserts when count >= AFULL_LVL
- `AEMPTY_LVL`, 2, `aempty` asserts when count <= AEMPTY_LVL
- `FWFT`, 0, 0 = standard registered read; 1 = first-word-fall-through

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wdata`  in  WORDSIZE  write data
- `winc`  in  1  push request
- `rinc`  in  1  pop request
- `rdata`  out  WORDSIZE  read data
- `rvalid`  out  1  `rdata` holds a valid word (meaning per mode, below)
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `afull`  out  1  almost-full
- `aempty`  out  1  almost-empty
- `count`  out  ADDRSIZE+1  current occupancy, 0..DEPTH
- `ovf`  out  1  sticky: push attempted while full
- `udf`  out  1  sticky: pop attempted while empty

## Operation
- Push accepted iff `winc && !full`: mem[wptr] <= wdata, wptr <= wptr+1 (mod DEPTH).
- Pop accepted iff `rinc && !empty`: rptr <= rptr+1 (mod DEPTH).
- Acceptance uses flags from the current cycle only: full + both strobes -> pop only; empty + both strobes -> push only, no bypass. Otherwise both accepted and count unchanged.
- count: +1 on push only, -1 on pop only, else hold. Flags derive from registered count, never from strobes.
- `winc` while full -> push dropped, memory untouched, `ovf` <= 1. `rinc` while empty -> `udf` <= 1, `rdata` and pointers unchanged. Both clear only on `rst`.
- FWFT=0: on an accepted pop, `rdata` <= mem[rptr] at the same edge, and `rvalid` is a 1-cycle pulse in the following cycle. Otherwise `rdata` holds its last value and `rvalid` = 0.
- FWFT=1: `rdata` = mem[rptr] continuously (asynchronous memory read), `rvalid` = !empty. `rinc` acknowledges the presented word. When empty, `rdata` is don't-care.
- Pointers are ADDRSIZE bits and wrap naturally. Full/empty ambiguity is resolved by count, not by a pointer wrap bit.
- Memory is not reset. Contents are stale after `rst`.

## Timing
- Reset (while `rst`=1 at an edge): wptr = rptr = 0, count = 0, empty = 1, full = 0, afull = (AFULL_LVL == 0), aempty = 1, rdata = 0, rvalid = 0, ovf = udf = 0. `winc`/`rinc` are ignored in that cycle.
- Reset mid-operation discards all queued words. The first push after reset lands at address 0.
- Flag and count latency: 1 edge after the accepting strobe. A push into an empty FIFO makes `empty` drop on that edge.
- FWFT=1: the first word is visible on `rdata` in the cycle after its push edge.
- FWFT=0: 1-cycle read latency from pop edge to `rdata`/`rvalid`.
- Back-to-back push/pop is sustained every cycle. Throughput is 1 word/cycle each direction.

## Test plan
- Fill (FWFT=0, defaults): push 100..107 on 8 consecutive cycles -> count = 8, full = 1 after the 8th edge, afull = 1 from count 6. 9th push 0xAA -> ovf = 1, count stays 8.
- Drain: 8 pops -> `rdata` = 100..107 in order, each with an `rvalid` pulse. Then empty = 1, aempty = 1. Extra pop -> udf = 1, `rdata` stays 107.
- Wrap-around: push 5, pop 5, then push 6 words 1..6 and pop 6 -> read order 1..6. Pointers crossed address 7 -> 0 with no corruption.
- Simultaneous: count = 3, assert `winc` + `rinc` for 4 cycles -> count stays 3 and order is preserved. At full with both strobes: pop only, count 8 -> 7, ovf stays 0. At empty with both strobes: push only, udf stays 0.
- FWFT=1: push 0x5A -> next cycle `rdata` = 0x5A, `rvalid` = 1 with no `rinc`. Pop -> `rvalid` = 0, empty = 1.
- Reset mid-op: at count = 5 with ovf = 1, assert `rst` one cycle -> all outputs at reset values. Push 0x11 then pop -> `rdata` = 0x11.

Source files
------------

// File: rtl/sync_fifo_buf.sv
// rtl/sync_fifo_buf.sv - single-clock FIFO with count, status/sticky flags and optional FWFT read
// Push/pop strobes only; occupancy count resolves full/empty instead of a pointer wrap bit.
module sync_fifo_buf #(
    parameter int WORDSIZE   = 8,
    parameter int ADDRSIZE   = 3,
    parameter int AFULL_LVL  = (1 << ADDRSIZE) - 2,
    parameter int AEMPTY_LVL = 2,
    parameter int FWFT       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORDSIZE-1:0] wdata,
    input  logic                winc,
    input  logic                rinc,
    output logic [WORDSIZE-1:0] rdata,
    output logic                rvalid,
    output logic                full,
    output logic                empty,
    output logic                afull,
    output logic                aempty,
    output logic [ADDRSIZE:0]   count,
    output logic                ovf,
    output logic                udf
);

    localparam int                DEPTH    = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] L_DEPTH  = DEPTH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] L_AFULL  = AFULL_LVL[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] L_AEMPTY = AEMPTY_LVL[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0]   L_CNT_ONE = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [ADDRSIZE-1:0] L_PTR_ONE = {{(ADDRSIZE-1){1'b0}}, 1'b1};

    logic [WORDSIZE-1:0] r_mem [DEPTH];
    logic [ADDRSIZE-1:0] r_wptr;
    logic [ADDRSIZE-1:0] r_rptr;
    logic [ADDRSIZE:0]   r_count;
    logic                r_ovf;
    logic                r_udf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = winc && !w_full;
    assign w_pop   = rinc && !w_empty;

    assign full   = w_full;
    assign empty  = w_empty;
    assign afull  = (r_count >= L_AFULL);
    assign aempty = (r_count <= L_AEMPTY);
    assign count  = r_count;
    assign ovf    = r_ovf;
    assign udf    = r_udf;

    // Storage is deliberately not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + L_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase
            // A simultaneous opposite strobe is served, so it is not an over/underflow.
            if (winc && w_full && !rinc) begin
                r_ovf <= 1'b1;
            end
            if (rinc && w_empty && !winc) begin
                r_udf <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rdata  = r_mem[r_rptr];
        assign rvalid = !w_empty;
    end else begin : g_std
        logic [WORDSIZE-1:0] r_rdata;
        logic                r_rvalid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_pop;
                if (w_pop) begin
                    r_rdata <= r_mem[r_rptr];
                end
            end
        end

        assign rdata  = r_rdata;
        assign rvalid = r_rvalid;
    end

endmodule

// File: tb/tb_sync_fifo_buf.sv
// tb/tb_sync_fifo_buf.sv - directed self-checking bench for sync_fifo_buf (standard and FWFT)
module tb_sync_fifo_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_wdata = '0;
    logic       s_winc = 1'b0;
    logic       s_rinc = 1'b0;
    logic [7:0] s_rdata;
    logic       s_rvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic [3:0] s_count;

    logic [7:0] f_wdata = '0;
    logic       f_winc = 1'b0;
    logic       f_rinc = 1'b0;
    logic [7:0] f_rdata;
    logic       f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [3:0] f_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_buf #(.FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wdata(s_wdata), .winc(s_winc), .rinc(s_rinc),
        .rdata(s_rdata), .rvalid(s_rvalid), .full(s_full), .empty(s_empty),
        .afull(s_afull), .aempty(s_aempty), .count(s_count), .ovf(s_ovf), .udf(s_udf)
    );

    sync_fifo_buf #(.FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .wdata(f_wdata), .winc(f_winc), .rinc(f_rinc),
        .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
        .afull(f_afull), .aempty(f_aempty), .count(f_count), .ovf(f_ovf), .udf(f_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs mid-cycle, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic w, input logic rd, input logic [7:0] d);
        @(negedge clk);
        rst = r; s_winc = w; s_rinc = rd; s_wdata = d;
        f_winc = 1'b0; f_rinc = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic fcyc(input logic w, input logic rd, input logic [7:0] d);
        @(negedge clk);
        rst = 1'b0; s_winc = 1'b0; s_rinc = 1'b0;
        f_winc = w; f_rinc = rd; f_wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"},  32'(s_count), 32'd0);
        chk({tag, "_empty"},  32'(s_empty), 32'd1);
        chk({tag, "_full"},   32'(s_full), 32'd0);
        chk({tag, "_afull"},  32'(s_afull), 32'd0);
        chk({tag, "_aempty"}, 32'(s_aempty), 32'd1);
        chk({tag, "_rdata"},  32'(s_rdata), 32'd0);
        chk({tag, "_rvalid"}, 32'(s_rvalid), 32'd0);
        chk({tag, "_ovf"},    32'(s_ovf), 32'd0);
        chk({tag, "_udf"},    32'(s_udf), 32'd0);
        chk({tag, "_f_count"}, 32'(f_count), 32'd0);
        chk({tag, "_f_rvalid"}, 32'(f_rvalid), 32'd0);
    endtask

    initial begin
        // Reset with a push strobe that must be ignored
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h99);
        chk_reset("rst");

        // Fill with 100..107
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'(99 + i));
            chk("fill_count",  32'(s_count), 32'(i));
            chk("fill_full",   32'(s_full), 32'(i == 8));
            chk("fill_afull",  32'(s_afull), 32'(i >= 6));
            chk("fill_aempty", 32'(s_aempty), 32'(i <= 2));
            chk("fill_empty",  32'(s_empty), 32'd0);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("ovf_set",   32'(s_ovf), 32'd1);
        chk("ovf_count", 32'(s_count), 32'd8);

        // Drain: expect 100..107 in order
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_rdata",  32'(s_rdata), 32'(100 + i));
            chk("drain_rvalid", 32'(s_rvalid), 32'd1);
            chk("drain_count",  32'(s_count), 32'(7 - i));
        end
        chk("drain_empty",  32'(s_empty), 32'd1);
        chk("drain_aempty", 32'(s_aempty), 32'd1);
        chk("drain_udf0",   32'(s_udf), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("udf_set",    32'(s_udf), 32'd1);
        chk("udf_rdata",  32'(s_rdata), 32'd107);
        chk("udf_rvalid", 32'(s_rvalid), 32'd0);
        chk("udf_count",  32'(s_count), 32'd0);

        // Wrap-around: pointers go 5 -> 7 -> 0 -> 3
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'(20 + i));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("wrapA_rdata", 32'(s_rdata), 32'(20 + i));
        end
        for (int i = 1; i <= 6; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i));
        chk("wrapB_count", 32'(s_count), 32'd6);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("wrapB_rdata",  32'(s_rdata), 32'(i));
            chk("wrapB_rvalid", 32'(s_rvalid), 32'd1);
        end
        chk("wrapB_empty", 32'(s_empty), 32'd1);

        // Simultaneous push/pop at count 3
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h31 + i));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 8'(8'h34 + i));
            chk("both_rdata", 32'(s_rdata), 32'(8'h31 + i));
            chk("both_count", 32'(s_count), 32'd3);
        end
        // Queue now 35,36,37; top up to full with 38..3C
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h38 + i));
        chk("both_full", 32'(s_full), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("fullboth_count", 32'(s_count), 32'd7);
        chk("fullboth_ovf",   32'(s_ovf), 32'd0);
        chk("fullboth_rdata", 32'(s_rdata), 32'h35);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            chk("fullboth_order", 32'(s_rdata), 32'(8'h36 + i));
        end
        chk("fullboth_empty", 32'(s_empty), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 8'h77);
        chk("emptyboth_count",  32'(s_count), 32'd1);
        chk("emptyboth_udf",    32'(s_udf), 32'd0);
        chk("emptyboth_rvalid", 32'(s_rvalid), 32'd0);
        chk("emptyboth_rdata",  32'(s_rdata), 32'h3C);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("emptyboth_pop", 32'(s_rdata), 32'h77);

        // Reset mid-operation at count 5 with ovf set
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        cyc(1'b0, 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("mid_count", 32'(s_count), 32'd5);
        chk("mid_ovf",   32'(s_ovf), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 8'h55);
        chk_reset("midrst");
        cyc(1'b0, 1'b1, 1'b0, 8'h11);
        chk("post_count", 32'(s_count), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_rdata",  32'(s_rdata), 32'h11);
        chk("post_rvalid", 32'(s_rvalid), 32'd1);
        chk("post_empty",  32'(s_empty), 32'd1);

        // FWFT instance
        fcyc(1'b1, 1'b0, 8'h5A);
        chk("fw_rdata",  32'(f_rdata), 32'h5A);
        chk("fw_rvalid", 32'(f_rvalid), 32'd1);
        chk("fw_count",  32'(f_count), 32'd1);
        fcyc(1'b0, 1'b0, 8'h00);
        chk("fw_hold_rdata",  32'(f_rdata), 32'h5A);
        chk("fw_hold_rvalid", 32'(f_rvalid), 32'd1);
        fcyc(1'b0, 1'b1, 8'h00);
        chk("fw_pop_rvalid", 32'(f_rvalid), 32'd0);
        chk("fw_pop_empty",  32'(f_empty), 32'd1);
        fcyc(1'b1, 1'b0, 8'hA1);
        fcyc(1'b1, 1'b0, 8'hA2);
        chk("fw_two_rdata", 32'(f_rdata), 32'hA1);
        fcyc(1'b0, 1'b1, 8'h00);
        chk("fw_next_rdata",  32'(f_rdata), 32'hA2);
        chk("fw_next_rvalid", 32'(f_rvalid), 32'd1);
        fcyc(1'b0, 1'b1, 8'h00);
        chk("fw_last_empty", 32'(f_empty), 32'd1);
        chk("fw_udf0",       32'(f_udf), 32'd0);
        fcyc(1'b0, 1'b1, 8'h00);
        chk("fw_udf1",       32'(f_udf), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
